ft245_sync_model: RTL and testbench

Parametrised bus-functional model of an FTDI FT245-style synchronous FIFO device, used as the virtual FTDI chip in host-interface simulation benches. It presents the device-side pins (data, RXF#/rde_n, TXE#, RD#, WR#, OE#, SIWU) to the core under test and exposes simple FIFO ports to the bench for loading host-to-core bytes and draining core-to-host bytes. Buffer depths, data width and TX back-pressure margin are parameters, so benches can exercise full/empty stalls that a fixed-script model cannot.

---
 rtl/ft245_sync_model_if.sv | 31 +++
 rtl/ft245_sync_model.sv | 215 +++++++++++++++++++++
 tb/tb_ft245_sync_model.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft245_sync_model_if.sv
// -----------------------------------------------------------------------------
// ft245_sync_model_if
// Device-side handshake pins of an FT245-style synchronous FIFO chip.
//   ftdi_rde_n  RXF#: low while the device holds bytes for the core
//   ftdi_txe_n  TXE#: low while the device can accept bytes from the core
//   ftdi_rd_n   core read strobe
//   ftdi_wr_n   core write strobe
//   ftdi_oe_n   core output enable (turns the data bus toward the core)
//   ftdi_siwu   send-immediate / wake-up request
// Modports: master = core under test, slave = the device model.
// The data bus itself is bidirectional and stays a plain inout on the model,
// so tristate resolution happens on an ordinary net.
// -----------------------------------------------------------------------------
interface ft245_sync_model_if;
  logic ftdi_rde_n;
  logic ftdi_txe_n;
  logic ftdi_rd_n;
  logic ftdi_wr_n;
  logic ftdi_oe_n;
  logic ftdi_siwu;

  modport master (
    input  ftdi_rde_n, ftdi_txe_n,
    output ftdi_rd_n, ftdi_wr_n, ftdi_oe_n, ftdi_siwu
  );

  modport slave (
    output ftdi_rde_n, ftdi_txe_n,
    input  ftdi_rd_n, ftdi_wr_n, ftdi_oe_n, ftdi_siwu
  );
endinterface

// File: rtl/ft245_sync_model.sv
// -----------------------------------------------------------------------------
// ft245_sync_model
// Bus-functional model of an FT245-style synchronous FIFO device. The core
// under test sees the device pins; the bench loads host-to-core bytes into the
// RX buffer and drains core-to-host bytes from the TX buffer.
//
// Parameters: DATA_WIDTH, RX_DEPTH / TX_DEPTH (powers of two, >= 4),
//             TX_MARGIN (txe_n goes high once free TX entries <= TX_MARGIN).
// Ports:
//   ftdi_clk, rst     device clock; synchronous active-high reset
//   ftdi_data         bidirectional bus, driven only while oe_n=0 and rst=0
//   ftdi_if           handshake pins (slave modport)
//   host_rx_*         bench push side of the RX buffer (wr, data, hold, full, count)
//   host_tx_*         bench pop side of the TX buffer (rd, show-ahead data, empty, count)
//   siwu_count        count of SIWU rising edges, wraps at 16 bits
//   proto_err         sticky protocol-violation flag
// Optional: define FT245_MODEL_PROTO_CHECK_EN to build the protocol checker;
// without it proto_err is tied to 0.
// -----------------------------------------------------------------------------
module ft245_sync_model #(
  parameter int DATA_WIDTH = 8,
  parameter int RX_DEPTH   = 512,
  parameter int TX_DEPTH   = 512,
  parameter int TX_MARGIN  = 0
) (
  input  logic                          ftdi_clk,
  input  logic                          rst,
  inout  wire  [DATA_WIDTH-1:0]         ftdi_data,
  ft245_sync_model_if.slave             ftdi_if,
  input  logic                          host_rx_wr,
  input  logic [DATA_WIDTH-1:0]         host_rx_data,
  input  logic                          host_rx_hold,
  output logic                          host_rx_full,
  output logic [$clog2(RX_DEPTH+1)-1:0] host_rx_count,
  input  logic                          host_tx_rd,
  output logic [DATA_WIDTH-1:0]         host_tx_data,
  output logic                          host_tx_empty,
  output logic [$clog2(TX_DEPTH+1)-1:0] host_tx_count,
  output logic [15:0]                   siwu_count,
  output logic                          proto_err
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = $clog2(RX_DEPTH+1);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = $clog2(TX_DEPTH+1);

  logic [DATA_WIDTH-1:0] r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]      r_rx_wptr, r_rx_rptr;
  logic [RX_CW-1:0]      r_rx_count, w_rx_count_nxt;
  logic                  r_rde_n;
  logic                  w_rx_full, w_rx_push, w_rx_pop;
  logic [DATA_WIDTH-1:0] w_rx_head;

  logic [DATA_WIDTH-1:0] r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]      r_tx_wptr, r_tx_rptr;
  logic [TX_CW-1:0]      r_tx_count, w_tx_count_nxt;
  logic                  r_txe_n;
  logic                  w_tx_full, w_tx_push, w_tx_pop;

  logic                  r_siwu_q;
  logic [15:0]           r_siwu_count;

  // ---------------------------------------------------------------- RX path
  assign w_rx_full = (r_rx_count == RX_CW'(RX_DEPTH));
  // rde_n low already implies data is present; the count term keeps a pop
  // from ever underflowing the buffer.
  assign w_rx_pop  = !ftdi_if.ftdi_rd_n && !ftdi_if.ftdi_oe_n && !r_rde_n &&
                     (r_rx_count != '0);
  // A push at full is accepted only when a pop frees the slot on the same edge.
  assign w_rx_push = host_rx_wr && (!w_rx_full || w_rx_pop);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned, which would infer a latch.
  always_comb begin
    w_rx_count_nxt = r_rx_count;
    if (w_rx_push && !w_rx_pop)      w_rx_count_nxt = r_rx_count + RX_CW'(1);
    else if (!w_rx_push && w_rx_pop) w_rx_count_nxt = r_rx_count - RX_CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
      r_rde_n    <= 1'b1;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_AW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_AW'(1);
      r_rx_count <= w_rx_count_nxt;
      // Looking at the next count lets the emptying pop raise rde_n on its own edge.
      r_rde_n    <= host_rx_hold || (w_rx_count_nxt == '0);
    end
  end

  // NOTE: buffer storage has no reset; the pointers define what is valid, and
  // leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge ftdi_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= host_rx_data;
  end

  assign w_rx_head = (r_rx_count != '0) ? r_rx_mem[r_rx_rptr] : '0;
  assign ftdi_data = (!ftdi_if.ftdi_oe_n && !rst) ? w_rx_head : 'z;

  // ---------------------------------------------------------------- TX path
  assign w_tx_full = (r_tx_count == TX_CW'(TX_DEPTH));
  assign w_tx_push = !ftdi_if.ftdi_wr_n && !r_txe_n && ftdi_if.ftdi_oe_n && !w_tx_full;
  assign w_tx_pop  = host_tx_rd && (r_tx_count != '0);

  always_comb begin
    w_tx_count_nxt = r_tx_count;
    if (w_tx_push && !w_tx_pop)      w_tx_count_nxt = r_tx_count + TX_CW'(1);
    else if (!w_tx_push && w_tx_pop) w_tx_count_nxt = r_tx_count - TX_CW'(1);
  end

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
      r_txe_n    <= 1'b1;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_AW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_AW'(1);
      r_tx_count <= w_tx_count_nxt;
      // The write that lands on this edge is counted, so back-pressure appears
      // on the same edge that uses up the margin.
      r_txe_n    <= (TX_DEPTH - int'(w_tx_count_nxt)) <= TX_MARGIN;
    end
  end

  always_ff @(posedge ftdi_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= ftdi_data;
  end

  // ---------------------------------------------------------------- SIWU
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_siwu_q     <= 1'b0;
      r_siwu_count <= '0;
    end else begin
      r_siwu_q <= ftdi_if.ftdi_siwu;
      if (ftdi_if.ftdi_siwu && !r_siwu_q) r_siwu_count <= r_siwu_count + 16'(1);
    end
  end

  // ---------------------------------------------------------------- outputs
  assign ftdi_if.ftdi_rde_n = r_rde_n;
  assign ftdi_if.ftdi_txe_n = r_txe_n;
  assign host_rx_full       = w_rx_full;
  assign host_rx_count      = r_rx_count;
  assign host_tx_data       = r_tx_mem[r_tx_rptr];
  assign host_tx_empty      = (r_tx_count == '0);
  assign host_tx_count      = r_tx_count;
  assign siwu_count         = r_siwu_count;

`ifdef FT245_MODEL_PROTO_CHECK_EN
  // Device state machine; it only feeds the protocol checker.
  typedef enum logic [1:0] {RX_IDLE, RX_OE, RX_READ} rx_state_t;
  typedef enum logic       {TX_IDLE, TX_WRITE}       tx_state_t;

  rx_state_t   r_rx_state, w_rx_state_nxt;
  tx_state_t   r_tx_state, w_tx_state_nxt;
  logic        r_oe_n_q;
  logic        r_proto_err;
  logic [31:0] r_cycle;
  logic [4:0]  w_viol;

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    unique case (r_rx_state)
      RX_IDLE: if (!ftdi_if.ftdi_oe_n && !r_rde_n) w_rx_state_nxt = RX_OE;
      // Releasing oe_n before any read abandons the access.
      RX_OE:   if (ftdi_if.ftdi_oe_n)              w_rx_state_nxt = RX_IDLE;
               else if (!ftdi_if.ftdi_rd_n)        w_rx_state_nxt = RX_READ;
      RX_READ: if (ftdi_if.ftdi_oe_n || r_rde_n)   w_rx_state_nxt = RX_IDLE;
      default:                                     w_rx_state_nxt = RX_IDLE;
    endcase
    w_tx_state_nxt = ftdi_if.ftdi_wr_n ? TX_IDLE : TX_WRITE;
  end

  assign w_viol[0] = !ftdi_if.ftdi_rd_n && r_oe_n_q;
  assign w_viol[1] = !ftdi_if.ftdi_rd_n && r_rde_n;
  assign w_viol[2] = !ftdi_if.ftdi_wr_n && r_txe_n;
  assign w_viol[3] = !ftdi_if.ftdi_wr_n && !ftdi_if.ftdi_oe_n;
  assign w_viol[4] = !ftdi_if.ftdi_wr_n && (r_rx_state != RX_IDLE);

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_rx_state  <= RX_IDLE;
      r_tx_state  <= TX_IDLE;
      r_oe_n_q    <= 1'b1;
      r_proto_err <= 1'b0;
      r_cycle     <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_tx_state <= w_tx_state_nxt;
      r_oe_n_q   <= ftdi_if.ftdi_oe_n;
      r_cycle    <= r_cycle + 32'd1;
      if (|w_viol) begin
        r_proto_err <= 1'b1;
        $display("ft245_sync_model: protocol violation at cycle %0d, flags %05b, rx %s, tx %s",
                 r_cycle, w_viol, r_rx_state.name(), r_tx_state.name());
      end
    end
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_ft245_sync_model.sv
// -----------------------------------------------------------------------------
// tb_ft245_sync_model
// Directed bench for ft245_sync_model (RX_DEPTH=4, TX_DEPTH=8, TX_MARGIN=2).
// Stimulus pushes expected bytes into rx_q / tx_q as they are issued; a
// negedge monitor pops and compares whenever the core pops RX data or the
// bench pops TX data. Flag and count checks are made inline.
// The bus carries pull-ups so an undriven (Z) bus reads as all ones.
// -----------------------------------------------------------------------------
module tb_ft245_sync_model;
  logic       ftdi_clk = 1'b0;
  logic       rst;
  wire  [7:0] ftdi_data;
  logic [7:0] tb_wdata;
  logic       host_rx_wr, host_rx_hold, host_tx_rd;
  logic [7:0] host_rx_data, host_tx_data;
  logic       host_rx_full, host_tx_empty;
  logic [2:0] host_rx_count;
  logic [3:0] host_tx_count;
  logic [15:0] siwu_count;
  logic       proto_err;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

`ifdef FT245_MODEL_PROTO_CHECK_EN
  localparam logic PROTO_ON = 1'b1;
`else
  localparam logic PROTO_ON = 1'b0;
`endif

  ft245_sync_model_if u_if ();

  always #5 ftdi_clk = ~ftdi_clk;

  // The core side only drives the bus while it is not asking for output.
  assign ftdi_data = u_if.ftdi_oe_n ? tb_wdata : 'z;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (ftdi_data[g]);
  end

  ft245_sync_model #(
    .DATA_WIDTH(8), .RX_DEPTH(4), .TX_DEPTH(8), .TX_MARGIN(2)
  ) dut (
    .ftdi_clk      (ftdi_clk),
    .rst           (rst),
    .ftdi_data     (ftdi_data),
    .ftdi_if       (u_if),
    .host_rx_wr    (host_rx_wr),
    .host_rx_data  (host_rx_data),
    .host_rx_hold  (host_rx_hold),
    .host_rx_full  (host_rx_full),
    .host_rx_count (host_rx_count),
    .host_tx_rd    (host_tx_rd),
    .host_tx_data  (host_tx_data),
    .host_tx_empty (host_tx_empty),
    .host_tx_count (host_tx_count),
    .siwu_count    (siwu_count),
    .proto_err     (proto_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ftdi_clk);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] b, input bit accept);
    host_rx_wr   = 1'b1;
    host_rx_data = b;
    if (accept) rx_q.push_back(b);
    tick();
    host_rx_wr = 1'b0;
  endtask

  // Scoreboard monitor: samples on the falling edge, i.e. the values the
  // next rising edge will act on.
  always @(negedge ftdi_clk) begin
    if (!rst) begin
      if (!u_if.ftdi_rd_n && !u_if.ftdi_oe_n && !u_if.ftdi_rde_n) begin
        if (rx_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rx_unexpected_pop: bus %02h, no byte expected", ftdi_data);
        end else check("rx_byte", 32'(ftdi_data), 32'(rx_q.pop_front()));
      end
      if (host_tx_rd && !host_tx_empty) begin
        if (tx_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL tx_unexpected_pop: data %02h, no byte expected", host_tx_data);
        end else check("tx_byte", 32'(host_tx_data), 32'(tx_q.pop_front()));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    rst = 1'b1;
    u_if.ftdi_rd_n = 1'b1; u_if.ftdi_wr_n = 1'b1; u_if.ftdi_siwu = 1'b0;
    u_if.ftdi_oe_n = 1'b0;  // bus must stay Z in reset even with oe asserted
    host_rx_wr = 1'b0; host_rx_data = '0; host_rx_hold = 1'b0; host_tx_rd = 1'b0;
    tb_wdata = '0;
    repeat (3) tick();

    // ---- reset state
    check("rst_rde_n", u_if.ftdi_rde_n, 1);
    check("rst_txe_n", u_if.ftdi_txe_n, 1);
    check("rst_rx_count", host_rx_count, 0);
    check("rst_tx_count", host_tx_count, 0);
    check("rst_tx_empty", host_tx_empty, 1);
    check("rst_rx_full", host_rx_full, 0);
    check("rst_siwu", siwu_count, 0);
    check("rst_proto", proto_err, 0);
    check("rst_bus_z", ftdi_data, 8'hFF);
    u_if.ftdi_oe_n = 1'b1; rst = 1'b0;
    tick();
    check("txe_after_rst", u_if.ftdi_txe_n, 0);
    check("rde_after_rst", u_if.ftdi_rde_n, 1);

    // ---- three-byte RX read
    push_rx(8'h11, 1);
    check("rde_low_after_push", u_if.ftdi_rde_n, 0);
    push_rx(8'h22, 1);
    push_rx(8'h33, 1);
    check("rx_count_3", host_rx_count, 3);
    u_if.ftdi_oe_n = 1'b0; tick();
    check("bus_head", ftdi_data, 8'h11);
    u_if.ftdi_rd_n = 1'b0; tick();
    check("bus_next", ftdi_data, 8'h22);
    tick(); tick();
    check("rde_high_on_last_pop", u_if.ftdi_rde_n, 1);
    check("rx_count_0", host_rx_count, 0);
    check("bus_empty_zero", ftdi_data, 8'h00);
    u_if.ftdi_rd_n = 1'b1; u_if.ftdi_oe_n = 1'b1; tick();

    // ---- hold keeps rde_n high while data is retained
    host_rx_hold = 1'b1;
    push_rx(8'h5A, 1);
    check("hold_rde_n", u_if.ftdi_rde_n, 1);
    check("hold_count", host_rx_count, 1);
    host_rx_hold = 1'b0; tick();
    check("unhold_rde_n", u_if.ftdi_rde_n, 0);

    // ---- simultaneous push and pop with count=1
    u_if.ftdi_oe_n = 1'b0; tick();
    u_if.ftdi_rd_n = 1'b0;
    host_rx_wr = 1'b1; host_rx_data = 8'h6B; rx_q.push_back(8'h6B);
    tick();
    host_rx_wr = 1'b0;
    check("simul_count", host_rx_count, 1);
    check("simul_order", ftdi_data, 8'h6B);
    tick();
    check("simul_drained", host_rx_count, 0);
    u_if.ftdi_rd_n = 1'b1; u_if.ftdi_oe_n = 1'b1; tick();

    // ---- fill to full, drop the fifth, push+pop at full
    push_rx(8'hA1, 1); push_rx(8'hA2, 1); push_rx(8'hA3, 1); push_rx(8'hA4, 1);
    push_rx(8'hA5, 0);
    check("rx_full", host_rx_full, 1);
    check("rx_count_full", host_rx_count, 4);
    u_if.ftdi_oe_n = 1'b0; tick();
    u_if.ftdi_rd_n = 1'b0;
    host_rx_wr = 1'b1; host_rx_data = 8'hA6; rx_q.push_back(8'hA6);
    tick();
    host_rx_wr = 1'b0;
    check("full_simul_count", host_rx_count, 4);
    check("full_simul_full", host_rx_full, 1);
    repeat (4) tick();
    check("full_drain_count", host_rx_count, 0);
    check("full_drain_rde", u_if.ftdi_rde_n, 1);
    u_if.ftdi_rd_n = 1'b1; u_if.ftdi_oe_n = 1'b1; tick();

    // ---- TX continuous writes against margin 2
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (u_if.ftdi_txe_n == 1'b0) begin
        u_if.ftdi_wr_n = 1'b0;
        tb_wdata = 8'(8'hD0 + i);
        tx_q.push_back(tb_wdata);
        n_acc++;
      end else u_if.ftdi_wr_n = 1'b1;
      tick();
      if (i == 0) check("tx_empty_after_write", host_tx_empty, 0);
    end
    u_if.ftdi_wr_n = 1'b1;
    check("tx_accepted", n_acc, 6);
    check("tx_count_6", host_tx_count, 6);
    check("txe_high_margin", u_if.ftdi_txe_n, 1);
    host_tx_rd = 1'b1; tick(); host_tx_rd = 1'b0;
    check("txe_restored", u_if.ftdi_txe_n, 0);
    check("tx_count_5", host_tx_count, 5);
    host_tx_rd = 1'b1;
    repeat (5) tick();
    check("tx_drained_empty", host_tx_empty, 1);
    tick();  // pop while empty is ignored
    check("tx_empty_pop_count", host_tx_count, 0);
    host_tx_rd = 1'b0;

    // ---- TX simultaneous write and bench pop
    u_if.ftdi_wr_n = 1'b0; tb_wdata = 8'hE0; tx_q.push_back(8'hE0); tick();
    tb_wdata = 8'hE1; tx_q.push_back(8'hE1); host_tx_rd = 1'b1; tick();
    u_if.ftdi_wr_n = 1'b1; host_tx_rd = 1'b0;
    check("tx_simul_count", host_tx_count, 1);
    host_tx_rd = 1'b1; tick(); host_tx_rd = 1'b0;
    check("tx_simul_empty", host_tx_empty, 1);

    // ---- SIWU edge counting
    u_if.ftdi_siwu = 1'b1; tick(); tick();
    u_if.ftdi_siwu = 1'b0; tick();
    u_if.ftdi_siwu = 1'b1; tick();
    u_if.ftdi_siwu = 1'b0; tick();
    check("siwu_count", siwu_count, 2);
    check("proto_clean", proto_err, 0);

    // ---- reset in the middle of a streaming RX burst
    u_if.ftdi_wr_n = 1'b0; tb_wdata = 8'hC7; tx_q.push_back(8'hC7); tick();
    u_if.ftdi_wr_n = 1'b1;
    u_if.ftdi_oe_n = 1'b0; tick();
    for (int i = 0; i < 6; i++) begin
      host_rx_wr = 1'b1; host_rx_data = 8'(8'hF0 + i); rx_q.push_back(host_rx_data);
      u_if.ftdi_rd_n = (i == 0);
      tick();
    end
    check("burst_count", host_rx_count, 1);
    host_rx_data = 8'hF6;
    rst = 1'b1;
    rx_q.delete(); tx_q.delete();
    tick();
    check("midrst_rde_n", u_if.ftdi_rde_n, 1);
    check("midrst_txe_n", u_if.ftdi_txe_n, 1);
    check("midrst_rx_count", host_rx_count, 0);
    check("midrst_tx_count", host_tx_count, 0);
    check("midrst_bus_z", ftdi_data, 8'hFF);
    u_if.ftdi_rd_n = 1'b1; u_if.ftdi_oe_n = 1'b1; host_rx_wr = 1'b0;
    tick();

    // ---- write while txe_n is still high right after reset
    rst = 1'b0; u_if.ftdi_wr_n = 1'b0; tb_wdata = 8'h99;
    tick();
    u_if.ftdi_wr_n = 1'b1;
    check("wr_txe_high_rejected", host_tx_count, 0);
    check("proto_err_set", proto_err, 32'(PROTO_ON));
    tick(); tick();
    check("proto_err_sticky", proto_err, 32'(PROTO_ON));
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("proto_err_cleared", proto_err, 0);

    check("rx_q_drained", rx_q.size(), 0);
    check("tx_q_drained", tx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
